chnlnk_frame_seq: RTL and testbench

Parametrised channel-link frame sequencer. It replaces the fixed 96-data/4-tail frame FSM with configurable frame geometry, link back-pressure, a frame counter and optional triple-modular redundancy. It sits between the sample FIFO/L1A buffer and the channel-link serialiser and CRC generator. It drives FIFO reads, word-valid, sequence number, CRC clear and last-word markers.

---
 rtl/chnlnk_pkg.sv | 31 +++
 rtl/tmr_vote.sv | 20 ++
 rtl/chnlnk_frame_seq.sv | 177 +++++++++++++++++
 tb/tb_chnlnk_frame_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chnlnk_pkg.sv
// Shared types and helpers for the channel-link frame sequencer.
// State codes match the legacy frame FSM so FRM_STATE stays readable in existing tools.
package chnlnk_pkg;

    localparam int FRM_ST_W = 3;

    typedef enum logic [FRM_ST_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_LAST_WORD   = 3'd1,
        ST_READ        = 3'd2,
        ST_STRT_SAMPLE = 3'd3,
        ST_TAIL_END    = 3'd4,
        ST_TAIL_NO_END = 3'd5,
        ST_W4DATA      = 3'd6,
        ST_ILLEGAL     = 3'd7
    } frm_state_e;

    typedef struct packed {
        logic clr_crc;
        logic rd;
        logic valid;
        logic last_wrd;
    } frm_flags_t;

    localparam int FRM_FLAGS_W = $bits(frm_flags_t);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter for one triplicated register field.
module tmr_vote
    import chnlnk_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : gen_bit
            assign y[gi] = maj3(a[gi], b[gi], c[gi]);
        end
    endgenerate

endmodule

// File: rtl/chnlnk_frame_seq.sv
// Channel-link frame sequencer: configurable data/tail geometry, serialiser stall,
// completed-frame counter and optional triplicated registers with majority voting.
module chnlnk_frame_seq
    import chnlnk_pkg::*;
#(
    parameter int DATA_WORDS = 96,
    parameter int TAIL_WORDS = 4,
    parameter int SEQ_W      = 7,
    parameter int CNT_W      = 16,
    parameter int TMR        = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                L1A_BUF_MT,
    input  logic                F_MT,
    input  logic                END_EVT,
    input  logic                STALL,
    output logic                CLR_CRC,
    output logic                RD,
    output logic                VALID,
    output logic                LAST_WRD,
    output logic [SEQ_W-1:0]    SEQ,
    output logic [FRM_ST_W-1:0] FRM_STATE,
    output logic [CNT_W-1:0]    FRM_CNT
);

    localparam int NCOPY = (TMR != 0) ? 3 : 1;
    localparam logic [SEQ_W-1:0] LAST_DATA_SEQ = SEQ_W'(DATA_WORDS - 1);
    localparam logic [SEQ_W-1:0] LAST_TAIL_SEQ = SEQ_W'(DATA_WORDS + TAIL_WORDS - 1);

    frm_state_e       state_v;
    frm_state_e       state_next;
    logic [SEQ_W-1:0] seq_v;
    logic [SEQ_W-1:0] seq_next;
    frm_flags_t       flags_v;
    frm_flags_t       flags_next;
    logic [CNT_W-1:0] cnt_v;
    logic [CNT_W-1:0] cnt_next;
    logic             frozen;

    // Next values are always derived from the voted copies so an upset copy is overwritten.
    always_comb begin
        state_next = ST_IDLE;
        seq_next   = '0;
        flags_next = '0;
        cnt_next   = cnt_v;
        frozen     = STALL && (state_v inside {ST_STRT_SAMPLE, ST_READ,
                                               ST_TAIL_END, ST_TAIL_NO_END});
        if (frozen) begin
            state_next = state_v;
            seq_next   = seq_v;
        end else begin
            case (state_v)
                ST_IDLE: begin
                    if (!L1A_BUF_MT) begin
                        state_next         = ST_W4DATA;
                        flags_next.clr_crc = 1'b1;
                    end
                end
                ST_W4DATA: begin
                    if (!F_MT && !STALL) begin
                        state_next       = ST_STRT_SAMPLE;
                        flags_next.rd    = 1'b1;
                        flags_next.valid = 1'b1;
                    end else begin
                        state_next = ST_W4DATA;
                    end
                end
                ST_STRT_SAMPLE: begin
                    state_next       = ST_READ;
                    seq_next         = seq_v + SEQ_W'(1);
                    flags_next.rd    = 1'b1;
                    flags_next.valid = 1'b1;
                end
                ST_READ: begin
                    seq_next         = seq_v + SEQ_W'(1);
                    flags_next.valid = 1'b1;
                    if (seq_v == LAST_DATA_SEQ) begin
                        state_next = END_EVT ? ST_TAIL_END : ST_TAIL_NO_END;
                    end else begin
                        state_next    = ST_READ;
                        flags_next.rd = 1'b1;
                    end
                end
                ST_TAIL_END, ST_TAIL_NO_END: begin
                    if (seq_v == LAST_TAIL_SEQ) begin
                        cnt_next = cnt_v + CNT_W'(1);
                        if (state_v == ST_TAIL_END) begin
                            state_next          = ST_LAST_WORD;
                            flags_next.last_wrd = 1'b1;
                        end else begin
                            state_next         = ST_W4DATA;
                            flags_next.clr_crc = 1'b1;
                        end
                    end else begin
                        state_next       = state_v;
                        seq_next         = seq_v + SEQ_W'(1);
                        flags_next.valid = 1'b1;
                    end
                end
                // Last_Word and the unused code 7 both fall back to Idle with outputs low.
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCOPY; gi++) begin : gen_copy
            frm_state_e       state_reg;
            logic [SEQ_W-1:0] seq_reg;
            frm_flags_t       flags_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_reg <= ST_IDLE;
                    seq_reg   <= '0;
                    flags_reg <= '0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    seq_reg   <= seq_next;
                    flags_reg <= flags_next;
                    cnt_reg   <= cnt_next;
                end
            end
        end

        if (TMR != 0) begin : gen_vote
            logic [FRM_ST_W-1:0]    state_bits;
            logic [FRM_FLAGS_W-1:0] flags_bits;

            tmr_vote #(.W(FRM_ST_W)) u_vote_state (
                .a(gen_copy[0].state_reg),
                .b(gen_copy[1].state_reg),
                .c(gen_copy[2].state_reg),
                .y(state_bits)
            );
            tmr_vote #(.W(SEQ_W)) u_vote_seq (
                .a(gen_copy[0].seq_reg),
                .b(gen_copy[1].seq_reg),
                .c(gen_copy[2].seq_reg),
                .y(seq_v)
            );
            tmr_vote #(.W(FRM_FLAGS_W)) u_vote_flags (
                .a(gen_copy[0].flags_reg),
                .b(gen_copy[1].flags_reg),
                .c(gen_copy[2].flags_reg),
                .y(flags_bits)
            );
            tmr_vote #(.W(CNT_W)) u_vote_cnt (
                .a(gen_copy[0].cnt_reg),
                .b(gen_copy[1].cnt_reg),
                .c(gen_copy[2].cnt_reg),
                .y(cnt_v)
            );

            assign state_v = frm_state_e'(state_bits);
            assign flags_v = frm_flags_t'(flags_bits);
        end else begin : gen_single
            assign state_v = gen_copy[0].state_reg;
            assign seq_v   = gen_copy[0].seq_reg;
            assign flags_v = gen_copy[0].flags_reg;
            assign cnt_v   = gen_copy[0].cnt_reg;
        end
    endgenerate

    assign CLR_CRC   = flags_v.clr_crc;
    assign RD        = flags_v.rd;
    assign VALID     = flags_v.valid;
    assign LAST_WRD  = flags_v.last_wrd;
    assign SEQ       = seq_v;
    assign FRM_STATE = state_v;
    assign FRM_CNT   = cnt_v;

endmodule

// File: tb/tb_chnlnk_frame_seq.sv
// Directed bench: default 96/4 TMR instance plus a small 8/2 single-copy instance.
module tb_chnlnk_frame_seq;
    import chnlnk_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        L1A_BUF_MT = 1'b1;
    logic        F_MT = 1'b0;
    logic        END_EVT = 1'b1;
    logic        STALL = 1'b0;

    logic        CLR_CRC, RD, VALID, LAST_WRD;
    logic [6:0]  SEQ;
    logic [2:0]  FRM_STATE;
    logic [15:0] FRM_CNT;

    logic        s_clr_crc, s_rd, s_valid, s_last_wrd;
    logic [3:0]  s_seq;
    logic [2:0]  s_frm_state;
    logic [1:0]  s_frm_cnt;

    int n_pass = 0;
    int n_total = 0;

    chnlnk_frame_seq dut (
        .CLK(CLK), .RST(RST), .L1A_BUF_MT(L1A_BUF_MT), .F_MT(F_MT),
        .END_EVT(END_EVT), .STALL(STALL),
        .CLR_CRC(CLR_CRC), .RD(RD), .VALID(VALID), .LAST_WRD(LAST_WRD),
        .SEQ(SEQ), .FRM_STATE(FRM_STATE), .FRM_CNT(FRM_CNT)
    );

    chnlnk_frame_seq #(
        .DATA_WORDS(8), .TAIL_WORDS(2), .SEQ_W(4), .CNT_W(2), .TMR(0)
    ) dut_s (
        .CLK(CLK), .RST(RST), .L1A_BUF_MT(L1A_BUF_MT), .F_MT(F_MT),
        .END_EVT(END_EVT), .STALL(STALL),
        .CLR_CRC(s_clr_crc), .RD(s_rd), .VALID(s_valid), .LAST_WRD(s_last_wrd),
        .SEQ(s_seq), .FRM_STATE(s_frm_state), .FRM_CNT(s_frm_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        #1;
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD, SEQ, FRM_STATE, FRM_CNT} !== '0)
            $display("FAIL reset_main: got %h expected 0",
                     {CLR_CRC, RD, VALID, LAST_WRD, SEQ, FRM_STATE, FRM_CNT});
        else n_pass++;
        n_total++;
        if ({s_clr_crc, s_rd, s_valid, s_last_wrd, s_seq, s_frm_state, s_frm_cnt} !== '0)
            $display("FAIL reset_small: got %h expected 0",
                     {s_clr_crc, s_rd, s_valid, s_last_wrd, s_seq, s_frm_state, s_frm_cnt});
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0000 || FRM_STATE !== 3'd0)
            $display("FAIL idle_hold: flags %b state %0d expected 0000 state 0",
                     {CLR_CRC, RD, VALID, LAST_WRD}, FRM_STATE);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [3:0] exp_f;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b1000 || FRM_STATE !== 3'd6)
            $display("FAIL single_clr: flags %b state %0d expected 1000 state 6",
                     {CLR_CRC, RD, VALID, LAST_WRD}, FRM_STATE);
        else n_pass++;
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_f = {1'b0, (i < 96), 1'b1, 1'b0};
            n_total++;
            if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'(i))
                $display("FAIL single_word: flags %b seq %0d expected %b seq %0d",
                         {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f, i);
            else n_pass++;
        end
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0001 || SEQ !== 7'd0 || FRM_STATE !== 3'd1)
            $display("FAIL single_last: flags %b seq %0d state %0d expected 0001 seq 0 state 1",
                     {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, FRM_STATE);
        else n_pass++;
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0000 || FRM_STATE !== 3'd0 || FRM_CNT !== 16'd1)
            $display("FAIL single_idle: flags %b state %0d cnt %0d expected 0000 state 0 cnt 1",
                     {CLR_CRC, RD, VALID, LAST_WRD}, FRM_STATE, FRM_CNT);
        else n_pass++;
    endtask

    task automatic test_continue();
        logic [3:0] exp_f;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b0; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b1000)
            $display("FAIL cont_first_clr: flags %b expected 1000", {CLR_CRC, RD, VALID, LAST_WRD});
        else n_pass++;
        L1A_BUF_MT = 1'b1;
        for (int f = 0; f < 4; f++) begin
            END_EVT = (f == 3);
            for (int i = 0; i < 100; i++) begin
                step();
                exp_f = {1'b0, (i < 96), 1'b1, 1'b0};
                n_total++;
                if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'(i))
                    $display("FAIL cont_word: frame %0d flags %b seq %0d expected %b seq %0d",
                             f, {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f, i);
                else n_pass++;
            end
            step();
            exp_f = (f < 3) ? 4'b1000 : 4'b0001;
            n_total++;
            if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'd0)
                $display("FAIL cont_gap: frame %0d flags %b seq %0d expected %b seq 0",
                         f, {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f);
            else n_pass++;
        end
        step();
        n_total++;
        if (FRM_STATE !== 3'd0 || FRM_CNT !== 16'd4 || {CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0000)
            $display("FAIL cont_count: state %0d cnt %0d expected state 0 cnt 4", FRM_STATE, FRM_CNT);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [3:0] exp_f;
        logic [2:0] exp_st;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_f = {1'b0, (i < 96), 1'b1, 1'b0};
            n_total++;
            if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'(i))
                $display("FAIL stall_word: flags %b seq %0d expected %b seq %0d",
                         {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f, i);
            else n_pass++;
            if (i == 40 || i == 97) begin
                exp_st = (i == 40) ? 3'd2 : 3'd4;
                STALL = 1'b1;
                for (int k = 0; k < ((i == 40) ? 5 : 3); k++) begin
                    step();
                    n_total++;
                    if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0000 || SEQ !== 7'(i) || FRM_STATE !== exp_st)
                        $display("FAIL stall_hold: flags %b seq %0d state %0d expected 0000 seq %0d state %0d",
                                 {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, FRM_STATE, i, exp_st);
                    else n_pass++;
                end
                STALL = 1'b0;
            end
        end
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0001)
            $display("FAIL stall_last: flags %b expected 0001", {CLR_CRC, RD, VALID, LAST_WRD});
        else n_pass++;
        step();
        n_total++;
        if (FRM_CNT !== 16'd1 || FRM_STATE !== 3'd0)
            $display("FAIL stall_count: cnt %0d state %0d expected cnt 1 state 0", FRM_CNT, FRM_STATE);
        else n_pass++;
    endtask

    task automatic test_small_geometry();
        logic [3:0] exp_f;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        for (int f = 0; f < 5; f++) begin
            step();
            n_total++;
            if ({s_clr_crc, s_rd, s_valid, s_last_wrd} !== 4'b1000 || s_frm_state !== 3'd6)
                $display("FAIL small_clr: frame %0d flags %b state %0d expected 1000 state 6",
                         f, {s_clr_crc, s_rd, s_valid, s_last_wrd}, s_frm_state);
            else n_pass++;
            for (int i = 0; i < 10; i++) begin
                step();
                exp_f = {1'b0, (i < 8), 1'b1, 1'b0};
                n_total++;
                if ({s_clr_crc, s_rd, s_valid, s_last_wrd} !== exp_f || s_seq !== 4'(i))
                    $display("FAIL small_word: frame %0d flags %b seq %0d expected %b seq %0d",
                             f, {s_clr_crc, s_rd, s_valid, s_last_wrd}, s_seq, exp_f, i);
                else n_pass++;
            end
            step();
            n_total++;
            if ({s_clr_crc, s_rd, s_valid, s_last_wrd} !== 4'b0001 || s_seq !== 4'd0)
                $display("FAIL small_last: frame %0d flags %b seq %0d expected 0001 seq 0",
                         f, {s_clr_crc, s_rd, s_valid, s_last_wrd}, s_seq);
            else n_pass++;
            step();
            n_total++;
            if (s_frm_cnt !== 2'((f + 1) % 4) || s_frm_state !== 3'd0)
                $display("FAIL small_count: frame %0d cnt %0d state %0d expected cnt %0d state 0",
                         f, s_frm_cnt, s_frm_state, (f + 1) % 4);
            else n_pass++;
        end
        L1A_BUF_MT = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp_f;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i <= 50; i++) step();
        n_total++;
        if (SEQ !== 7'd50 || VALID !== 1'b1)
            $display("FAIL mid_pre: seq %0d valid %b expected seq 50 valid 1", SEQ, VALID);
        else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD, SEQ, FRM_STATE, FRM_CNT} !== '0)
            $display("FAIL mid_async: got %h expected 0",
                     {CLR_CRC, RD, VALID, LAST_WRD, SEQ, FRM_STATE, FRM_CNT});
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        L1A_BUF_MT = 1'b0;
        step();
        n_total++;
        if ({CLR_CRC, RD, VALID, LAST_WRD} !== 4'b1000 || FRM_CNT !== 16'd0)
            $display("FAIL mid_restart: flags %b cnt %0d expected 1000 cnt 0",
                     {CLR_CRC, RD, VALID, LAST_WRD}, FRM_CNT);
        else n_pass++;
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_f = {1'b0, (i < 96), 1'b1, 1'b0};
            n_total++;
            if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'(i))
                $display("FAIL mid_word: flags %b seq %0d expected %b seq %0d",
                         {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f, i);
            else n_pass++;
        end
        step();
        step();
        n_total++;
        if (FRM_CNT !== 16'd1 || FRM_STATE !== 3'd0)
            $display("FAIL mid_count: cnt %0d state %0d expected cnt 1 state 0", FRM_CNT, FRM_STATE);
        else n_pass++;
    endtask

    task automatic test_tmr_upset();
        logic [3:0] exp_f;
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_f = {1'b0, (i < 96), 1'b1, 1'b0};
            n_total++;
            if ({CLR_CRC, RD, VALID, LAST_WRD} !== exp_f || SEQ !== 7'(i))
                $display("FAIL tmr_word: flags %b seq %0d expected %b seq %0d",
                         {CLR_CRC, RD, VALID, LAST_WRD}, SEQ, exp_f, i);
            else n_pass++;
            if (i == 31) begin
                n_total++;
                if (dut.gen_copy[1].state_reg !== ST_READ || dut.gen_copy[1].seq_reg !== 7'd31)
                    $display("FAIL tmr_reconverge: copy state %0d seq %0d expected state 2 seq 31",
                             dut.gen_copy[1].state_reg, dut.gen_copy[1].seq_reg);
                else n_pass++;
            end
            if (i == 30) begin
                #1;
                force dut.gen_copy[1].state_reg = ST_TAIL_END;
                force dut.gen_copy[1].seq_reg = 7'd99;
                #1;
                n_total++;
                if (FRM_STATE !== 3'd2 || SEQ !== 7'd30 || {CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0110)
                    $display("FAIL tmr_masked: state %0d seq %0d flags %b expected state 2 seq 30 flags 0110",
                             FRM_STATE, SEQ, {CLR_CRC, RD, VALID, LAST_WRD});
                else n_pass++;
                #1;
                release dut.gen_copy[1].state_reg;
                release dut.gen_copy[1].seq_reg;
            end
        end
        step();
        step();
        n_total++;
        if (FRM_CNT !== 16'd1 || FRM_STATE !== 3'd0)
            $display("FAIL tmr_count: cnt %0d state %0d expected cnt 1 state 0", FRM_CNT, FRM_STATE);
        else n_pass++;
    endtask

    task automatic test_illegal_state();
        L1A_BUF_MT = 1'b1; F_MT = 1'b0; END_EVT = 1'b1; STALL = 1'b0;
        do_reset();
        L1A_BUF_MT = 1'b0;
        step();
        L1A_BUF_MT = 1'b1;
        for (int i = 0; i <= 20; i++) step();
        n_total++;
        if (SEQ !== 7'd20 || FRM_STATE !== 3'd2)
            $display("FAIL illegal_pre: seq %0d state %0d expected seq 20 state 2", SEQ, FRM_STATE);
        else n_pass++;
        #1;
        force dut.gen_copy[0].state_reg = ST_ILLEGAL;
        force dut.gen_copy[1].state_reg = ST_ILLEGAL;
        force dut.gen_copy[2].state_reg = ST_ILLEGAL;
        step();
        release dut.gen_copy[0].state_reg;
        release dut.gen_copy[1].state_reg;
        release dut.gen_copy[2].state_reg;
        step();
        n_total++;
        if (FRM_STATE !== 3'd0 || SEQ !== 7'd0 || {CLR_CRC, RD, VALID, LAST_WRD} !== 4'b0000 || FRM_CNT !== 16'd0)
            $display("FAIL illegal_recover: state %0d seq %0d flags %b cnt %0d expected all 0",
                     FRM_STATE, SEQ, {CLR_CRC, RD, VALID, LAST_WRD}, FRM_CNT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continue();
        test_stall();
        test_small_geometry();
        test_reset_mid_frame();
        test_tmr_upset();
        test_illegal_state();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
